// File: rtl/timer.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers plus a maskable interrupt.
// Latency: register writes take effect on the next clock edge; read data and IRQ are combinational.
// Backpressure: none; every bus access completes in the cycle it is presented.
module timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_PRESET = 2'd1;
  localparam logic [1:0] OFS_COUNT  = 2'd2;
  localparam logic [1:0] MODE_AUTO  = 2'b01;

  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  state_t      state_q;
  logic        irq_flag_q, irq_flag_d;

  logic [1:0]  offset;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        addr_unused;

  // Only Addr[3:2] selects a register; the remaining address bits are don't-care.
  assign offset      = Addr[3:2];
  assign addr_unused = ^{Addr[31:4], Addr[1:0]};
  assign wr_ctrl     = WE && (offset == OFS_CTRL);
  assign wr_preset   = WE && (offset == OFS_PRESET);

  // Merge FSM-driven updates of CTRL and irq_flag with software writes; software has the last word.
  always_comb begin
    ctrl_d     = ctrl_q;
    irq_flag_d = irq_flag_q;
    if (state_q == CNT && ctrl_q[0] && count_q <= 32'd1) begin
      irq_flag_d = 1'b1;
    end
    if (state_q == INT) begin
      if (ctrl_q[2:1] == MODE_AUTO) begin
        irq_flag_d = 1'b0;
      end else begin
        ctrl_d[0] = 1'b0;
      end
    end
    if (wr_ctrl) begin
      ctrl_d = Din[3:0];
    end
    if (wr_ctrl || wr_preset) begin
      irq_flag_d = 1'b0;
    end
  end

  // Register file and countdown FSM; COUNT saturates at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      state_q    <= IDLE;
      irq_flag_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      irq_flag_q <= irq_flag_d;
      if (wr_preset) begin
        preset_q <= Din;
      end
      case (state_q)
        IDLE: begin
          if (ctrl_q[0]) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          count_q <= preset_q;
          state_q <= CNT;
        end
        CNT: begin
          if (!ctrl_q[0]) begin
            state_q <= IDLE;
          end else if (count_q > 32'd1) begin
            count_q <= count_q - 32'd1;
          end else begin
            count_q <= 32'd0;
            state_q <= INT;
          end
        end
        INT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Read mux; the reserved offset returns zero.
  always_comb begin
    Dout = 32'd0;
    case (offset)
      OFS_CTRL:   Dout = {28'd0, ctrl_q};
      OFS_PRESET: Dout = preset_q;
      OFS_COUNT:  Dout = count_q;
      default:    Dout = 32'd0;
    endcase
  end

  assign IRQ = irq_flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer.sv
// Directed bench for the timer: reads push expected {IRQ, Dout} into a queue,
// and a negedge monitor pops and compares whenever a read is presented.
module tb_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  logic        rd_vld;

  logic [32:0] exp_q[$];
  string       name_q[$];
  logic [32:0] exp_cur;
  string       name_cur;
  int          n_total = 0;
  int          n_pass  = 0;

  always #5 clk = ~clk;

  timer dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    tick();
    WE   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input logic ei, input string nm);
    Addr   = a;
    rd_vld = 1'b1;
    exp_q.push_back({ei, e});
    name_q.push_back(nm);
    tick();
    rd_vld = 1'b0;
  endtask

  // Monitor: compare the presented read against the oldest expectation.
  always @(negedge clk) begin
    if (rd_vld === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_underflow: Dout=%h IRQ=%b with no expected entry", Dout, IRQ);
      end else begin
        exp_cur  = exp_q.pop_front();
        name_cur = name_q.pop_front();
        if ({IRQ, Dout} === exp_cur) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got Dout=%h IRQ=%b, expected Dout=%h IRQ=%b",
                   name_cur, Dout, IRQ, exp_cur[31:0], exp_cur[32]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    WE     = 1'b0;
    Addr   = 32'd0;
    Din    = 32'd0;
    rd_vld = 1'b0;
    idle(2);
    reset = 1'b0;

    // Reset values and register access
    rd(32'h0, 32'h0, 1'b0, "rst_ctrl");
    rd(32'h4, 32'h0, 1'b0, "rst_preset");
    rd(32'h8, 32'h0, 1'b0, "rst_count");
    rd(32'hC, 32'h0, 1'b0, "rst_reserved");
    wr(32'h8, 32'd5);
    rd(32'h8, 32'h0, 1'b0, "count_readonly");
    wr(32'h0, 32'hFFFF_FFF8);
    rd(32'h0, 32'h8, 1'b0, "ctrl_upper_zero");
    wr(32'h0, 32'h0);
    wr(32'h4, 32'hDEAD_BEEF);
    rd(32'h4, 32'hDEAD_BEEF, 1'b0, "preset_rw");
    wr(32'hC, 32'h1234_5678);
    rd(32'hC, 32'h0, 1'b0, "reserved_wr_ignored");

    // Mode 0, PRESET=3
    wr(32'h4, 32'd3);
    wr(32'h0, 32'h9);
    rd(32'h8, 32'd0, 1'b0, "m0_e0");
    rd(32'h8, 32'd0, 1'b0, "m0_e1_load");
    rd(32'h8, 32'd3, 1'b0, "m0_e2");
    rd(32'h8, 32'd2, 1'b0, "m0_e3");
    rd(32'h8, 32'd1, 1'b0, "m0_e4");
    rd(32'h8, 32'd0, 1'b1, "m0_e5_irq");
    rd(32'h0, 32'h8, 1'b1, "m0_e6_ctrl");
    rd(32'h8, 32'd0, 1'b1, "m0_sticky");
    wr(32'h0, 32'h8);
    rd(32'h0, 32'h8, 1'b0, "m0_clear_by_write");

    // Mode 1, PRESET=2: one-cycle pulse every 5 cycles
    wr(32'h4, 32'd2);
    wr(32'h0, 32'hB);
    for (int k = 0; k < 16; k++) begin
      rd(32'h0, 32'hB, (k == 4 || k == 9 || k == 14), "m1_pulse");
    end
    wr(32'h0, 32'h8);
    idle(2);

    // Clear Enable mid-count, then restart from a new PRESET
    wr(32'h4, 32'd10);
    wr(32'h0, 32'h9);
    idle(4);
    rd(32'h8, 32'd8, 1'b0, "freeze_pre8");
    wr(32'h0, 32'h8);
    rd(32'h8, 32'd6, 1'b0, "freeze_a");
    rd(32'h8, 32'd6, 1'b0, "freeze_b");
    idle(3);
    rd(32'h8, 32'd6, 1'b0, "freeze_c");
    wr(32'h4, 32'd4);
    wr(32'h0, 32'h9);
    rd(32'h8, 32'd6, 1'b0, "restart_f0");
    rd(32'h8, 32'd6, 1'b0, "restart_f1");
    rd(32'h8, 32'd4, 1'b0, "restart_f2");
    rd(32'h8, 32'd3, 1'b0, "restart_f3");
    rd(32'h8, 32'd2, 1'b0, "restart_f4");
    rd(32'h8, 32'd1, 1'b0, "restart_f5");
    rd(32'h8, 32'd0, 1'b1, "restart_irq");
    rd(32'h0, 32'h8, 1'b1, "restart_ctrl");
    wr(32'h0, 32'h8);
    rd(32'h8, 32'd0, 1'b0, "restart_cleared");

    // PRESET=0 boundary: irq at E3
    wr(32'h4, 32'd0);
    wr(32'h0, 32'h9);
    rd(32'h8, 32'd0, 1'b0, "p0_e0");
    rd(32'h8, 32'd0, 1'b0, "p0_e1");
    rd(32'h8, 32'd0, 1'b0, "p0_e2");
    rd(32'h8, 32'd0, 1'b1, "p0_e3_irq");
    rd(32'h0, 32'h8, 1'b1, "p0_ctrl");
    wr(32'h0, 32'h8);

    // Masking with IM=0, then the same with IM=1
    wr(32'h4, 32'd1);
    wr(32'h0, 32'h1);
    rd(32'h0, 32'h1, 1'b0, "mask_e0");
    rd(32'h0, 32'h1, 1'b0, "mask_e1");
    rd(32'h0, 32'h1, 1'b0, "mask_e2");
    rd(32'h0, 32'h1, 1'b0, "mask_e3_masked");
    rd(32'h0, 32'h0, 1'b0, "mask_e4");
    wr(32'h0, 32'h8);
    rd(32'h0, 32'h8, 1'b0, "mask_unmask_cleared");
    wr(32'h4, 32'd1);
    wr(32'h0, 32'h9);
    rd(32'h8, 32'd0, 1'b0, "im1_e0");
    rd(32'h8, 32'd0, 1'b0, "im1_e1");
    rd(32'h8, 32'd1, 1'b0, "im1_e2");
    rd(32'h8, 32'd0, 1'b1, "im1_e3_irq");
    rd(32'h0, 32'h8, 1'b1, "im1_ctrl");
    wr(32'h0, 32'h8);
    rd(32'h0, 32'h8, 1'b0, "im1_cleared");

    // Reset mid-count at COUNT=7
    wr(32'h4, 32'd10);
    wr(32'h0, 32'h9);
    idle(4);
    rd(32'h8, 32'd8, 1'b0, "rst_mid_8");
    reset = 1'b1;
    rd(32'h8, 32'd7, 1'b0, "rst_mid_7");
    reset = 1'b0;
    rd(32'h0, 32'h0, 1'b0, "rst_mid_ctrl");
    rd(32'h4, 32'h0, 1'b0, "rst_mid_preset");
    rd(32'h8, 32'h0, 1'b0, "rst_mid_count");
    idle(3);
    rd(32'h8, 32'h0, 1'b0, "rst_mid_idle");

    idle(2);
    n_total++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
